pwm_capture: RTL and testbench
==============================

# pwm_capture

Measures an incoming PWM waveform, such as an LED drive or an external PWM source, and reports the high time and the period of each complete cycle in `clk` cycles. It is the receive-side counterpart of the PWM generators in the training designs and is used to close the loop on breathing/dimming outputs. A dead line (0 % or 100 % duty) is detected and flagged with a timeout instead of reporting a measurement.

## Interface
- `CNT_W`, 25: width of the internal counters and the measurement outputs.
- `TIMEOUT`, 24000000: number of cycles without a qualifying edge before the line is declared stuck. Must satisfy 2 ≤ `TIMEOUT` < 2^`CNT_W`.
- `FILT_LEN`, 4: glitch-filter length in cycles. Used only when the filter is compiled in.

- `clk`  in  1  system clock, 12 MHz.
- `rst`  in  1  asynchronous reset, active-high.
- `pwm_in`  in  1  PWM input, asynchronous to `clk`.
- `high_cnt`  out  `CNT_W`  high-phase length of the last complete period, in cycles.
- `period_cnt`  out  `CNT_W`  length of the last complete period (rise to rise), in cycles.
- `meas_valid`  out  1  one-cycle pulse when `high_cnt`/`period_cnt` update.
- `level_stuck`  out  1  high while no edge has been seen for `TIMEOUT` cycles.
- `stuck_level`  out  1  synchronized line level captured on entry to STUCK.

## Operation
- **Input path:** 2-FF synchronizer, then optional filter, giving `lvl`. `prev` is `lvl` delayed one cycle. `rise = lvl & ~prev`, `fall = ~lvl & prev`. All of these flops reset to 0.
- **State machine (IDLE, HIGH, LOW, STUCK):** reset state is IDLE.
  - **IDLE:** `pcnt` increments each cycle.
    - `rise` → HIGH with `pcnt` = 1 and `hcnt` = 1.
    - `fall` → `pcnt` = 0.
  - **HIGH:** `pcnt` and `hcnt` both increment.
    - `fall` → LOW. `pcnt` increments and `hcnt` holds.
  - **LOW:** `pcnt` increments.
    - `rise` → HIGH. On this edge `period_cnt` ← `pcnt`, `high_cnt` ← `hcnt`, `meas_valid` ← 1. Then `pcnt` = 1 and `hcnt` = 1.
  - **Any non-STUCK state:** if there is no edge this cycle and `pcnt` + 1 == `TIMEOUT`, go to STUCK. On that edge `level_stuck` ← 1, `stuck_level` ← `lvl`, and `pcnt` ← 0.
  - **STUCK:** counters hold at 0.
    - `rise` → HIGH with `pcnt` = 1, `hcnt` = 1, `level_stuck` ← 0.
    - `fall` → IDLE, `level_stuck` ← 0.
- **Arithmetic:** for an input that is high for H cycles and low for L cycles, the block reports `high_cnt` = H and `period_cnt` = H+L.
- **Counter width:** counters cannot overflow because the timeout fires first.
- **Simultaneous events:** an edge in the same cycle as the timeout wins, and the block does not enter STUCK.
- **First period:** the first rising edge after reset, or after STUCK, starts a period and does not produce `meas_valid`. The first valid report comes at the second rising edge.
- **Reset mid-operation:** all state is cleared immediately and asynchronously. Any partially measured period is discarded.

## Timing
- Reset values: `high_cnt` = 0, `period_cnt` = 0, `meas_valid` = 0, `level_stuck` = 0, `stuck_level` = 0.
- Latency: a `pwm_in` rise sampled at clk edge k updates `lvl` at edge k+1, and outputs update at edge k+2. The filter adds `FILT_LEN` cycles of latency.
- `meas_valid` is high for exactly one cycle. `high_cnt` and `period_cnt` hold their values until the next `meas_valid`.
- Minimum measurable phase is 1 cycle without the filter and `FILT_LEN` cycles with it.

## Configuration
- `PWM_CAPTURE_GLITCH_FILTER_EN` defined:
  - `lvl` changes only after `FILT_LEN` consecutive identical synchronized samples.
  - Pulses shorter than `FILT_LEN` are ignored, and reported counts exclude them.
- Undefined: `lvl` is the synchronizer output directly, and `FILT_LEN` is unused.

## Structure
- Package `pwm_capture_pkg` holds the state enum (`IDLE`, `HIGH`, `LOW`, `STUCK`) and the default width/timeout constants.
- Sub-module `pwm_edge_sync` contains the synchronizer, the optional filter and `prev`. It outputs `lvl`, `rise` and `fall`.
- The FSM and counters live in the top module.

## Test plan
- **Steady PWM:** H=3, L=5, `TIMEOUT`=64. Expect `meas_valid` once per 8 cycles starting at the second rise, with `high_cnt`=3 and `period_cnt`=8. No pulse at the first rise.
- **Duty change:** switch from H=3, L=5 to H=6, L=2 mid-stream. Expect the next report to be 3/8, then 6/8.
- **0 % duty:** hold `pwm_in`=0 after reset with `TIMEOUT`=64. Expect `level_stuck`=1 and `stuck_level`=0 after 64 cycles, and no `meas_valid`. A subsequent rise clears `level_stuck` at output latency.
- **100 % duty:** H=3, L=5, then hold `pwm_in` high. Expect STUCK with `stuck_level`=1 when `pcnt` reaches 64. A subsequent fall → IDLE with `level_stuck`=0.
- **Reset mid-period:** assert `rst` during HIGH. All outputs read 0 immediately. After release, the first report comes at the second rise.
- **Glitch filter:** with `PWM_CAPTURE_GLITCH_FILTER_EN` and `FILT_LEN`=4, H=10, L=10, plus a 2-cycle low glitch inside the high phase. Expect `high_cnt`=10 and `period_cnt`=20.

Source files
------------

// File: rtl/pwm_capture_pkg.sv
// Shared types and default constants for the PWM capture block.
package pwm_capture_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HIGH  = 2'd1,
    LOW   = 2'd2,
    STUCK = 2'd3
  } state_e;

  localparam int DEF_CNT_W    = 25;
  localparam int DEF_TIMEOUT  = 24000000;
  localparam int DEF_FILT_LEN = 4;

endpackage

// File: rtl/pwm_capture_if.sv
// PWM capture bundle: raw PWM input plus the measurement results.
// master is the capture block, slave is the source/consumer.
interface pwm_capture_if #(
  parameter int CNT_W = pwm_capture_pkg::DEF_CNT_W
);
  logic             pwm_in;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] period_cnt;
  logic             meas_valid;
  logic             level_stuck;
  logic             stuck_level;

  modport master (
    input  pwm_in,
    output high_cnt, period_cnt, meas_valid, level_stuck, stuck_level
  );

  modport slave (
    output pwm_in,
    input  high_cnt, period_cnt, meas_valid, level_stuck, stuck_level
  );
endinterface

// File: rtl/pwm_edge_sync.sv
// Input conditioning: 2-FF synchronizer, optional glitch filter, edge detect.
// Filter is compiled in with PWM_CAPTURE_GLITCH_FILTER_EN.
module pwm_edge_sync
  import pwm_capture_pkg::*;
#(
  parameter int FILT_LEN = DEF_FILT_LEN
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pwm,
  output logic o_lvl,
  output logic o_rise,
  output logic o_fall
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic w_lvl;

  // NOTE: every flop here resets to 0 so lvl and prev agree and no false edge follows reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      // NOTE: non-blocking so r_sync2 takes the old r_sync1, keeping two real stages.
      r_sync1 <= i_pwm;
      r_sync2 <= r_sync1;
    end
  end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int FC_W = $clog2(FILT_LEN + 1);

  logic [FC_W-1:0] r_filt_cnt;
  logic            r_lvl;

  // Count consecutive samples that disagree with lvl; flip after FILT_LEN of them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_filt_cnt <= '0;
      r_lvl      <= 1'b0;
    end else if (r_sync2 == r_lvl) begin
      r_filt_cnt <= '0;
    end else if (r_filt_cnt == FC_W'(FILT_LEN - 1)) begin
      r_lvl      <= r_sync2;
      r_filt_cnt <= '0;
    end else begin
      r_filt_cnt <= r_filt_cnt + FC_W'(1);
    end
  end

  assign w_lvl = r_lvl;
`else
  logic w_unused_filt_len;
  assign w_unused_filt_len = (FILT_LEN != 0);
  assign w_lvl             = r_sync2;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_prev <= 1'b0;
    else     r_prev <= w_lvl;
  end

  assign o_lvl  = w_lvl;
  assign o_rise = w_lvl & ~r_prev;
  assign o_fall = ~w_lvl & r_prev;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of a PWM input in clk cycles and flags a dead line.
// Optional glitch filter: define PWM_CAPTURE_GLITCH_FILTER_EN.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int TIMEOUT  = DEF_TIMEOUT,
  parameter int FILT_LEN = DEF_FILT_LEN
) (
  input  logic            clk,
  input  logic            rst,
  pwm_capture_if.master   bus
);

  logic w_lvl, w_rise, w_fall;

  pwm_edge_sync #(.FILT_LEN(FILT_LEN)) u_edge_sync (
    .clk    (clk),
    .rst    (rst),
    .i_pwm  (bus.pwm_in),
    .o_lvl  (w_lvl),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_pcnt, w_pcnt_nxt;
  logic [CNT_W-1:0] r_hcnt, w_hcnt_nxt;
  logic [CNT_W-1:0] r_high_cnt, w_high_nxt;
  logic [CNT_W-1:0] r_period_cnt, w_period_nxt;
  logic             r_meas_valid, w_valid_nxt;
  logic             r_level_stuck, w_stuck_nxt;
  logic             r_stuck_level, w_slvl_nxt;
  logic             w_timeout;

  // An edge in the timeout cycle wins, so the timeout only fires on a quiet cycle.
  assign w_timeout = (r_state != STUCK) && !w_rise && !w_fall &&
                     (r_pcnt + CNT_W'(1) == CNT_W'(TIMEOUT));

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_state_nxt  = r_state;
    w_pcnt_nxt   = r_pcnt;
    w_hcnt_nxt   = r_hcnt;
    w_high_nxt   = r_high_cnt;
    w_period_nxt = r_period_cnt;
    w_valid_nxt  = 1'b0;
    w_stuck_nxt  = r_level_stuck;
    w_slvl_nxt   = r_stuck_level;

    case (r_state)
      IDLE: begin
        w_pcnt_nxt = r_pcnt + CNT_W'(1);
        if (w_rise) begin
          w_state_nxt = HIGH;
          w_pcnt_nxt  = CNT_W'(1);
          w_hcnt_nxt  = CNT_W'(1);
        end else if (w_fall) begin
          w_pcnt_nxt = '0;
        end
      end
      HIGH: begin
        w_pcnt_nxt = r_pcnt + CNT_W'(1);
        if (w_fall) w_state_nxt = LOW;
        else        w_hcnt_nxt  = r_hcnt + CNT_W'(1);
      end
      LOW: begin
        w_pcnt_nxt = r_pcnt + CNT_W'(1);
        if (w_rise) begin
          w_period_nxt = r_pcnt;
          w_high_nxt   = r_hcnt;
          w_valid_nxt  = 1'b1;
          w_state_nxt  = HIGH;
          w_pcnt_nxt   = CNT_W'(1);
          w_hcnt_nxt   = CNT_W'(1);
        end
      end
      STUCK: begin
        if (w_rise) begin
          w_state_nxt = HIGH;
          w_pcnt_nxt  = CNT_W'(1);
          w_hcnt_nxt  = CNT_W'(1);
          w_stuck_nxt = 1'b0;
        end else if (w_fall) begin
          w_state_nxt = IDLE;
          w_stuck_nxt = 1'b0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    if (w_timeout) begin
      w_state_nxt = STUCK;
      w_stuck_nxt = 1'b1;
      w_slvl_nxt  = w_lvl;
      w_pcnt_nxt  = '0;
      w_hcnt_nxt  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_pcnt        <= '0;
      r_hcnt        <= '0;
      r_high_cnt    <= '0;
      r_period_cnt  <= '0;
      r_meas_valid  <= 1'b0;
      r_level_stuck <= 1'b0;
      r_stuck_level <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pcnt        <= w_pcnt_nxt;
      r_hcnt        <= w_hcnt_nxt;
      r_high_cnt    <= w_high_nxt;
      r_period_cnt  <= w_period_nxt;
      r_meas_valid  <= w_valid_nxt;
      r_level_stuck <= w_stuck_nxt;
      r_stuck_level <= w_slvl_nxt;
    end
  end

  assign bus.high_cnt    = r_high_cnt;
  assign bus.period_cnt  = r_period_cnt;
  assign bus.meas_valid  = r_meas_valid;
  assign bus.level_stuck = r_level_stuck;
  assign bus.stuck_level = r_stuck_level;

endmodule

// File: tb/tb_pwm_capture.sv
// Testbench for pwm_capture: timestamp-based reference model plus directed literal checks.
`timescale 1ns/1ps
module tb_pwm_capture;

  localparam int CNT_W    = 16;
  localparam int TIMEOUT  = 64;
  localparam int FILT_LEN = 4;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int FLAT = FILT_LEN;
`else
  localparam int FLAT = 0;
`endif
  // Cycles from a pwm_in change being sampled to the outputs reacting.
  localparam int LAT = 2 + FLAT;

  logic clk;
  logic rst;

  pwm_capture_if #(.CNT_W(CNT_W)) bus ();

  pwm_capture #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT),
    .FILT_LEN(FILT_LEN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_pulses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: works on timestamps of edges of the conditioned level.
  bit               pw_hist[$];
  bit               lv_hist[$];
  int               e_idx     = 0;
  bit               m_stuck   = 0;
  bit               m_started = 0;
  bit               m_fallen  = 0;
  int               t_rise    = 0;
  int               t_fall    = 0;
  int               t_start   = 0;
  logic [CNT_W-1:0] exp_high   = '0;
  logic [CNT_W-1:0] exp_period = '0;
  bit               exp_valid  = 0;
  bit               exp_stuck  = 0;
  bit               exp_slvl   = 0;

  function automatic bit pw_at(int i);
    return (i < 0) ? 1'b0 : pw_hist[i];
  endfunction

  function automatic bit lv_at(int i);
    return (i < 0) ? 1'b0 : lv_hist[i];
  endfunction

  task automatic model_reset();
    pw_hist.delete();
    lv_hist.delete();
    e_idx = 0; m_stuck = 0; m_started = 0; m_fallen = 0;
    t_rise = 0; t_fall = 0; t_start = 0;
    exp_high = '0; exp_period = '0; exp_valid = 0; exp_stuck = 0; exp_slvl = 0;
  endtask

  task automatic model_step();
    bit nl, cur, prv, rise, fall;
    pw_hist.push_back(bus.pwm_in);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    begin
      bit same;
      same = 1'b1;
      for (int j = e_idx - FILT_LEN - 1; j <= e_idx - 2; j++)
        if (pw_at(j) != pw_at(e_idx - 2)) same = 1'b0;
      nl = same ? pw_at(e_idx - 2) : lv_at(e_idx - 1);
    end
`else
    nl = pw_at(e_idx - 1);
`endif
    lv_hist.push_back(nl);
    cur  = lv_at(e_idx - 1);
    prv  = lv_at(e_idx - 2);
    rise = cur & ~prv;
    fall = ~cur & prv;
    exp_valid = 1'b0;
    if (m_stuck) begin
      if (rise) begin
        m_stuck = 0; m_started = 1; m_fallen = 0;
        t_rise = e_idx; t_start = e_idx; exp_stuck = 0;
      end else if (fall) begin
        m_stuck = 0; m_started = 0; t_start = e_idx + 1; exp_stuck = 0;
      end
    end else if (rise) begin
      if (m_started && m_fallen) begin
        exp_high   = CNT_W'(t_fall - t_rise);
        exp_period = CNT_W'(e_idx - t_rise);
        exp_valid  = 1'b1;
      end
      m_started = 1; m_fallen = 0; t_rise = e_idx; t_start = e_idx;
    end else if (fall) begin
      if (m_started) begin
        m_fallen = 1; t_fall = e_idx;
      end else begin
        t_start = e_idx + 1;
      end
    end else if (e_idx - t_start + 1 == TIMEOUT) begin
      m_stuck = 1; m_started = 0; exp_stuck = 1; exp_slvl = cur;
    end
    e_idx++;
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step();
    end
  end

  // Compare every cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      check("high_cnt",    32'(bus.high_cnt),    32'(exp_high));
      check("period_cnt",  32'(bus.period_cnt),  32'(exp_period));
      check("meas_valid",  32'(bus.meas_valid),  32'(exp_valid));
      check("level_stuck", 32'(bus.level_stuck), 32'(exp_stuck));
      check("stuck_level", 32'(bus.stuck_level), 32'(exp_slvl));
      if (bus.meas_valid) n_pulses++;
    end
  end

  task automatic phase(input bit v, input int n);
    bus.pwm_in = v;
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_high"},   32'(bus.high_cnt),    0);
    check({tag, "_period"}, 32'(bus.period_cnt),  0);
    check({tag, "_valid"},  32'(bus.meas_valid),  0);
    check({tag, "_stuck"},  32'(bus.level_stuck), 0);
    check({tag, "_slvl"},   32'(bus.stuck_level), 0);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_zero("async_rst");
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic int pick_len();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 7)      return int'($urandom_range(1, 12));
    else if (r < 9) return int'($urandom_range(60, 66));
    else            return int'($urandom_range(67, 100));
  endfunction

  int p0;

  initial begin
    rst        = 1'b1;
    bus.pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    #1 check_zero("reset");
    rst = 1'b0;

`ifndef PWM_CAPTURE_GLITCH_FILTER_EN
    // Steady 3/5 PWM: no report at the first rise, then one per period.
    phase(0, 2);
    p0 = n_pulses;
    phase(1, 3); phase(0, 5);
    check("first_rise_no_pulse", 32'(n_pulses - p0), 0);
    repeat (5) begin phase(1, 3); phase(0, 5); end
    check("steady_pulses", 32'(n_pulses - p0), 5);
    check("steady_high",   32'(bus.high_cnt),   3);
    check("steady_period", 32'(bus.period_cnt), 8);

    // Duty change to 6/2: next report still 3/8, then 6/8.
    phase(1, 6);
    check("duty_pulses", 32'(n_pulses - p0), 6);
    check("duty_first_high",   32'(bus.high_cnt),   3);
    check("duty_first_period", 32'(bus.period_cnt), 8);
    phase(0, 2); phase(1, 6);
    check("duty_second_high",   32'(bus.high_cnt),   6);
    check("duty_second_period", 32'(bus.period_cnt), 8);
    phase(0, 2);

    // 100 % duty after a 3/5 period.
    phase(1, 3); phase(0, 5); phase(1, 80);
    check("full_stuck", 32'(bus.level_stuck), 1);
    check("full_slvl",  32'(bus.stuck_level), 1);
    check("full_hold_high",   32'(bus.high_cnt),   3);
    check("full_hold_period", 32'(bus.period_cnt), 8);
    phase(0, LAT + 1);
    check("full_release", 32'(bus.level_stuck), 0);
`else
    // 10/10 PWM with a 2-cycle low glitch inside the high phase.
    phase(0, 6);
    p0 = n_pulses;
    repeat (4) begin phase(1, 4); phase(0, 2); phase(1, 4); phase(0, 10); end
    check("glitch_pulses", 32'(n_pulses - p0), 3);
    check("glitch_high",   32'(bus.high_cnt),   10);
    check("glitch_period", 32'(bus.period_cnt), 20);
    check("glitch_stuck",  32'(bus.level_stuck), 0);
`endif

    // 0 % duty from reset, then a rise clears the flag at output latency.
    pulse_reset();
    p0 = n_pulses;
    phase(0, 70);
    check("zero_stuck",  32'(bus.level_stuck), 1);
    check("zero_slvl",   32'(bus.stuck_level), 0);
    check("zero_pulses", 32'(n_pulses - p0), 0);
    phase(1, LAT);
    check("zero_still_stuck", 32'(bus.level_stuck), 1);
    phase(1, 1);
    check("zero_release", 32'(bus.level_stuck), 0);
    phase(1, 10);

    // Reset in the middle of a high phase.
    phase(0, 6); phase(1, 6); phase(0, 6); phase(1, 8);
    check("pre_rst_high",   32'(bus.high_cnt),   6);
    check("pre_rst_period", 32'(bus.period_cnt), 12);
    pulse_reset();
    p0 = n_pulses;
    phase(0, 4); phase(1, 6); phase(0, 6);
    check("post_rst_no_pulse", 32'(n_pulses - p0), 0);
    phase(1, 6);
    check("post_rst_pulses", 32'(n_pulses - p0), 1);
    check("post_rst_high",   32'(bus.high_cnt),   6);
    check("post_rst_period", 32'(bus.period_cnt), 12);

    // Fall coinciding with the timeout cycle: the edge wins.
    phase(0, 6); phase(1, TIMEOUT - 1); phase(0, 8);
    check("edge_wins_stuck", 32'(bus.level_stuck), 0);
    phase(1, 8);
    check("edge_wins_high",   32'(bus.high_cnt),   TIMEOUT - 1);
    check("edge_wins_period", 32'(bus.period_cnt), TIMEOUT - 1 + 8);

    // One cycle longer high phase does time out.
    phase(0, 8); phase(1, TIMEOUT); phase(0, LAT);
    check("timeout_stuck", 32'(bus.level_stuck), 1);
    check("timeout_slvl",  32'(bus.stuck_level), 1);
    phase(0, 8);
    check("timeout_release", 32'(bus.level_stuck), 0);

    // Random phase lengths around and beyond the timeout.
    for (int i = 0; i < 60; i++) begin
      int h;
      int l;
      h = pick_len();
      l = pick_len();
      phase(1, h);
      phase(0, l);
    end
    phase(0, 5);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
